// File: rtl/otter_cu_fsm_pkg.sv
// Shared OTTER control definitions: FSM state encoding plus opcode/funct3 constants,
// used by both the sequential control FSM and the combinational decoder.
package otter_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_MRET   = 3'b000;

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Control-unit bus: instruction fields and interrupt request in, datapath strobes out.
interface otter_cu_fsm_if #(
  parameter int CNT_W = 32
);
  logic             intr;
  logic [6:0]       ir6_0;
  logic [2:0]       ir14_12;
  logic             PCWrite;
  logic             regWrite;
  logic             memWE2;
  logic             memRDEN1;
  logic             memRDEN2;
  logic             reset;
  logic             csr_WE;
  logic             int_taken;
  logic             mret_exec;
  logic             illegal_op;
  logic [CNT_W-1:0] instret;
  logic [2:0]       state_dbg;

  modport master (
    input  intr, ir6_0, ir14_12,
    output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset,
           csr_WE, int_taken, mret_exec, illegal_op, instret, state_dbg
  );

  modport slave (
    output intr, ir6_0, ir14_12,
    input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset,
           csr_WE, int_taken, mret_exec, illegal_op, instret, state_dbg
  );
endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER control FSM: sequences FETCH/EXEC/WB/INTR, emits datapath strobes,
// counts retired instructions and flags unsupported opcodes.
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic          CLK,
  input  logic          RST,
  otter_cu_fsm_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;

  logic w_pc_write, w_reg_write, w_mem_we2, w_mem_rden1, w_mem_rden2;
  logic w_reset, w_csr_we, w_int_taken, w_mret_exec, w_illegal_op;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_INIT;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = ST_INIT;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_we2    = 1'b0;
    w_mem_rden1  = 1'b0;
    w_mem_rden2  = 1'b0;
    w_reset      = 1'b0;
    w_csr_we     = 1'b0;
    w_int_taken  = 1'b0;
    w_mret_exec  = 1'b0;
    w_illegal_op = 1'b0;

    case (r_state)
      ST_INIT: begin
        w_reset = 1'b1;
        w_next  = ST_FETCH;
      end
      ST_FETCH: begin
        w_mem_rden1 = 1'b1;
        w_next      = ST_EXEC;
      end
      ST_EXEC: begin
        w_next = bus.intr ? ST_INTR : ST_FETCH;
        case (bus.ir6_0)
          OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            w_pc_write  = 1'b1;
            w_reg_write = 1'b1;
          end
          OP_LOAD: begin
            w_mem_rden2 = 1'b1;
            w_next      = ST_WB;
          end
          OP_STORE: begin
            w_mem_we2  = 1'b1;
            w_pc_write = 1'b1;
          end
          OP_BRANCH: w_pc_write = 1'b1;
          OP_SYS: begin
            w_pc_write = 1'b1;
            if (bus.ir14_12 == F3_CSRRW) begin
              w_csr_we    = 1'b1;
              w_reg_write = 1'b1;
            end else if (bus.ir14_12 == F3_MRET) begin
              w_mret_exec = 1'b1;
            end else begin
              w_illegal_op = 1'b1;
            end
          end
          // Unknown or undefined opcodes retire as a NOP so X never reaches the datapath.
          default: begin
            w_illegal_op = 1'b1;
            w_pc_write   = 1'b1;
          end
        endcase
      end
      ST_WB: begin
        w_pc_write  = 1'b1;
        w_reg_write = 1'b1;
        w_next      = bus.intr ? ST_INTR : ST_FETCH;
      end
      ST_INTR: begin
        w_int_taken = 1'b1;
        w_pc_write  = 1'b1;
        w_next      = ST_FETCH;
      end
      default: w_next = ST_INIT;
    endcase

    // A reset arriving mid-instruction aborts it: nothing may commit on that edge.
    if (RST) begin
      w_pc_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_we2    = 1'b0;
      w_mem_rden2  = 1'b0;
      w_csr_we     = 1'b0;
      w_int_taken  = 1'b0;
      w_mret_exec  = 1'b0;
      w_illegal_op = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      r_instret <= '0;
    else if (w_pc_write && (r_state != ST_INTR))
      r_instret <= r_instret + 1'b1;
  end

  assign bus.PCWrite    = w_pc_write;
  assign bus.regWrite   = w_reg_write;
  assign bus.memWE2     = w_mem_we2;
  assign bus.memRDEN1   = w_mem_rden1;
  assign bus.memRDEN2   = w_mem_rden2;
  assign bus.reset      = w_reset;
  assign bus.csr_WE     = w_csr_we;
  assign bus.int_taken  = w_int_taken;
  assign bus.mret_exec  = w_mret_exec;
  assign bus.illegal_op = w_illegal_op;
  assign bus.instret    = r_instret;
  assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed self-checking bench for otter_cu_fsm with a 4-bit retire counter.
module tb_otter_cu_fsm;

  localparam int CNT_W = 4;

  logic CLK;
  logic RST;
  int   errors;
  int   checks;

  otter_cu_fsm_if #(.CNT_W(CNT_W)) bus ();

  otter_cu_fsm #(.CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [6:0] strobes();
    return {bus.PCWrite, bus.regWrite, bus.memWE2, bus.memRDEN2,
            bus.csr_WE, bus.mret_exec, bus.illegal_op};
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    bus.intr = 1'b0;
    bus.ir6_0 = 7'b0;
    bus.ir14_12 = 3'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if (bus.state_dbg !== 3'd0 || bus.reset !== 1'b1 || bus.instret !== 4'd0 || bus.PCWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: state=%0d reset=%b instret=%0d pcw=%b, want state=0 reset=1 instret=0 pcw=0",
               bus.state_dbg, bus.reset, bus.instret, bus.PCWrite);
    end
    tick();
    checks++;
    if (bus.state_dbg !== 3'd1 || bus.memRDEN1 !== 1'b1 || bus.reset !== 1'b0) begin
      errors++;
      $display("FAIL reset_fetch: state=%0d rden1=%b reset=%b, want state=1 rden1=1 reset=0",
               bus.state_dbg, bus.memRDEN1, bus.reset);
    end
    $display("txn reset: state=%0d instret=%0d", bus.state_dbg, bus.instret);
  endtask

  task automatic test_add();
    bus.ir6_0 = 7'b0110011;
    tick();
    checks++;
    if (bus.state_dbg !== 3'd2 || bus.PCWrite !== 1'b1 || bus.regWrite !== 1'b1) begin
      errors++;
      $display("FAIL add_exec: state=%0d pcw=%b rw=%b, want 2 1 1", bus.state_dbg, bus.PCWrite, bus.regWrite);
    end
    tick();
    checks++;
    if (bus.state_dbg !== 3'd1 || bus.instret !== 4'd1) begin
      errors++;
      $display("FAIL add_retire: state=%0d instret=%0d, want 1 1", bus.state_dbg, bus.instret);
    end
    $display("txn add: instret=%0d", bus.instret);
  endtask

  task automatic test_load_intr();
    bus.ir6_0 = 7'b0000011;
    tick();
    bus.intr = 1'b1;
    #1;
    checks++;
    if (bus.state_dbg !== 3'd2 || bus.memRDEN2 !== 1'b1 || bus.PCWrite !== 1'b0 || bus.regWrite !== 1'b0) begin
      errors++;
      $display("FAIL load_exec: state=%0d rden2=%b pcw=%b rw=%b, want 2 1 0 0",
               bus.state_dbg, bus.memRDEN2, bus.PCWrite, bus.regWrite);
    end
    tick();
    checks++;
    if (bus.state_dbg !== 3'd3 || bus.regWrite !== 1'b1 || bus.PCWrite !== 1'b1 || bus.instret !== 4'd1) begin
      errors++;
      $display("FAIL load_wb: state=%0d rw=%b pcw=%b instret=%0d, want 3 1 1 1",
               bus.state_dbg, bus.regWrite, bus.PCWrite, bus.instret);
    end
    tick();
    checks++;
    if (bus.state_dbg !== 3'd4 || bus.int_taken !== 1'b1 || bus.PCWrite !== 1'b1 ||
        bus.regWrite !== 1'b0 || bus.instret !== 4'd2) begin
      errors++;
      $display("FAIL load_intr: state=%0d int=%b pcw=%b rw=%b instret=%0d, want 4 1 1 0 2",
               bus.state_dbg, bus.int_taken, bus.PCWrite, bus.regWrite, bus.instret);
    end
    bus.intr = 1'b0;
    tick();
    checks++;
    if (bus.state_dbg !== 3'd1 || bus.instret !== 4'd2 || bus.int_taken !== 1'b0) begin
      errors++;
      $display("FAIL load_after_intr: state=%0d instret=%0d int=%b, want 1 2 0",
               bus.state_dbg, bus.instret, bus.int_taken);
    end
    $display("txn load+intr: instret=%0d", bus.instret);
  endtask

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] exp;   // {PCWrite,regWrite,memWE2,memRDEN2,csr_WE,mret_exec,illegal_op}
  } vec_t;

  task automatic test_opcodes();
    vec_t tbl [6];
    logic [3:0] exp_cnt;
    tbl[0] = '{"store",   7'b0100011, 3'b010, 7'b1010000};
    tbl[1] = '{"branch",  7'b1100011, 3'b000, 7'b1000000};
    tbl[2] = '{"csrrw",   7'b1110011, 3'b001, 7'b1100100};
    tbl[3] = '{"mret",    7'b1110011, 3'b000, 7'b1000010};
    tbl[4] = '{"illegal", 7'b1111111, 3'b000, 7'b1000001};
    tbl[5] = '{"sys_bad", 7'b1110011, 3'b010, 7'b1000001};
    exp_cnt = 4'd2;
    for (int i = 0; i < 6; i++) begin
      bus.ir6_0 = tbl[i].op;
      bus.ir14_12 = tbl[i].f3;
      tick();
      checks++;
      if (bus.state_dbg !== 3'd2 || strobes() !== tbl[i].exp) begin
        errors++;
        $display("FAIL op_%s: state=%0d strobes=%b, want state=2 strobes=%b",
                 tbl[i].name, bus.state_dbg, strobes(), tbl[i].exp);
      end
      tick();
      exp_cnt = exp_cnt + 4'd1;
      checks++;
      if (bus.state_dbg !== 3'd1 || bus.instret !== exp_cnt || bus.illegal_op !== 1'b0) begin
        errors++;
        $display("FAIL op_%s_retire: state=%0d instret=%0d ill=%b, want 1 %0d 0",
                 tbl[i].name, bus.state_dbg, bus.instret, bus.illegal_op, exp_cnt);
      end
      $display("txn %s: strobes=%b instret=%0d", tbl[i].name, tbl[i].exp, bus.instret);
    end
    bus.ir14_12 = 3'b000;
  endtask

  task automatic test_intr_nonload();
    bus.intr = 1'b1;
    bus.ir6_0 = 7'b0110011;
    tick();
    checks++;
    if (bus.state_dbg !== 3'd2 || bus.int_taken !== 1'b0) begin
      errors++;
      $display("FAIL intr_fetch_ignored: state=%0d int=%b, want 2 0", bus.state_dbg, bus.int_taken);
    end
    tick();
    checks++;
    if (bus.state_dbg !== 3'd4 || bus.int_taken !== 1'b1 || bus.instret !== 4'd9) begin
      errors++;
      $display("FAIL intr_entry: state=%0d int=%b instret=%0d, want 4 1 9",
               bus.state_dbg, bus.int_taken, bus.instret);
    end
    tick();
    checks++;
    if (bus.state_dbg !== 3'd1 || bus.instret !== 4'd9) begin
      errors++;
      $display("FAIL intr_no_resample: state=%0d instret=%0d, want 1 9", bus.state_dbg, bus.instret);
    end
    bus.intr = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.state_dbg !== 3'd1 || bus.instret !== 4'd10) begin
      errors++;
      $display("FAIL intr_resume: state=%0d instret=%0d, want 1 10", bus.state_dbg, bus.instret);
    end
    $display("txn add+intr: instret=%0d", bus.instret);
  endtask

  task automatic test_wrap_and_abort();
    logic [4:0] n;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (bus.state_dbg !== 3'd0 || bus.instret !== 4'd0) begin
      errors++;
      $display("FAIL wrap_reset: state=%0d instret=%0d, want 0 0", bus.state_dbg, bus.instret);
    end
    tick();
    bus.ir6_0 = 7'b0110011;
    for (int i = 1; i <= 16; i++) begin
      tick();
      tick();
      n = 5'(i);
      checks++;
      if (bus.instret !== n[3:0] || bus.state_dbg !== 3'd1) begin
        errors++;
        $display("FAIL wrap_add%0d: instret=%0d state=%0d, want %0d 1", i, bus.instret, bus.state_dbg, n[3:0]);
      end
      if (i >= 15) $display("txn add%0d: instret=%0d", i, bus.instret);
    end
    tick();
    RST = 1'b1;
    #1;
    checks++;
    if (bus.state_dbg !== 3'd2 || bus.PCWrite !== 1'b0 || bus.regWrite !== 1'b0) begin
      errors++;
      $display("FAIL abort_exec: state=%0d pcw=%b rw=%b, want 2 0 0", bus.state_dbg, bus.PCWrite, bus.regWrite);
    end
    tick();
    RST = 1'b0;
    checks++;
    if (bus.state_dbg !== 3'd0 || bus.instret !== 4'd0 || bus.reset !== 1'b1) begin
      errors++;
      $display("FAIL abort_init: state=%0d instret=%0d reset=%b, want 0 0 1",
               bus.state_dbg, bus.instret, bus.reset);
    end
    $display("txn abort: state=%0d instret=%0d", bus.state_dbg, bus.instret);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add();
    test_load_intr();
    test_opcodes();
    test_intr_nonload();
    test_wrap_and_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
